// File: rtl/cpu_pkg.sv
//------------------------------------------------------------------------------
// Module      : cpu_pkg
// Description : Shared widths and encodings for the 19-bit pipelined processor.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package cpu_pkg;

    localparam int DATA_W = 19;
    localparam int PC_W   = 15;
    localparam int REG_W  = 5;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_MUL = 3'b010,
        ALU_DIV = 3'b011,
        ALU_MOD = 3'b100,
        ALU_AND = 3'b101,
        ALU_OR  = 3'b110,
        ALU_XOR = 3'b111
    } alu_op_t;

    // Writeback source select carried through to the W stage
    localparam logic [1:0] RESULT_ALU = 2'b00;
    localparam logic [1:0] RESULT_MEM = 2'b01;
    localparam logic [1:0] RESULT_PC  = 2'b10;

endpackage

`default_nettype wire

// File: rtl/alu.sv
//------------------------------------------------------------------------------
// Module      : alu
// Description : Single-cycle unsigned ALU for the execute stage.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module alu
    import cpu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  alu_op_t           op,
    output logic [DATA_W-1:0] result,
    output logic              zero
);

    localparam logic [DATA_W-1:0] C_ALL_ONES = '1;

    logic w_bIsZero;
    assign w_bIsZero = (b == '0);

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_MUL: result = a * b;
            // Divide-by-zero results are architectural, not traps
            ALU_DIV: result = w_bIsZero ? C_ALL_ONES : (a / b);
            ALU_MOD: result = w_bIsZero ? a : (a % b);
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

`default_nettype wire

// File: rtl/execute.sv
//------------------------------------------------------------------------------
// Module      : execute
// Description : Execute stage: operand select, ALU, branch resolve, E/M register.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module execute
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWriteE,
    input  logic              MemWriteE,
    input  logic              JumpE,
    input  logic              BranchE,
    input  logic              ALUSrcE,
    input  logic [1:0]        ResultSrcE,
    input  logic [2:0]        ALUControlE,
    input  logic [DATA_W-1:0] RD1E,
    input  logic [DATA_W-1:0] RD2E,
    input  logic [DATA_W-1:0] ImmExtE,
    input  logic [PC_W-1:0]   PCE,
    input  logic [REG_W-1:0]  RDE,
    input  logic [DATA_W-1:0] ResultW,
    output logic              PCSrcE,
    output logic [PC_W-1:0]   PCTargetE,
    output logic              RegWriteM,
    output logic              MemWriteM,
    output logic [1:0]        ResultSrcM,
    output logic [REG_W-1:0]  RDM,
    output logic [DATA_W-1:0] WriteDataM,
    output logic [DATA_W-1:0] ALUResultM
);

    logic [DATA_W-1:0] w_srcB;
    logic [DATA_W-1:0] w_aluResult;
    logic              w_zero;

    // Forwarding hook not yet wired into the operand path
    logic w_unusedResultW;
    assign w_unusedResultW = ^ResultW;

    assign w_srcB = ALUSrcE ? ImmExtE : RD2E;

    alu u_alu (
        .a      (RD1E),
        .b      (w_srcB),
        .op     (alu_op_t'(ALUControlE)),
        .result (w_aluResult),
        .zero   (w_zero)
    );

    assign PCSrcE    = JumpE | (BranchE & w_zero);
    assign PCTargetE = PCE + ImmExtE[PC_W-1:0];

    logic              r_regWrite;
    logic              r_memWrite;
    logic [1:0]        r_resultSrc;
    logic [REG_W-1:0]  r_rd;
    logic [DATA_W-1:0] r_writeData;
    logic [DATA_W-1:0] r_aluResult;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_regWrite  <= 1'b0;
            r_memWrite  <= 1'b0;
            r_resultSrc <= '0;
            r_rd        <= '0;
            r_writeData <= '0;
            r_aluResult <= '0;
        end else begin
            r_regWrite  <= RegWriteE;
            r_memWrite  <= MemWriteE;
            r_resultSrc <= ResultSrcE;
            r_rd        <= RDE;
            r_writeData <= RD2E;
            r_aluResult <= w_aluResult;
        end
    end

    assign RegWriteM  = r_regWrite;
    assign MemWriteM  = r_memWrite;
    assign ResultSrcM = r_resultSrc;
    assign RDM        = r_rd;
    assign WriteDataM = r_writeData;
    assign ALUResultM = r_aluResult;

endmodule

`default_nettype wire

// File: tb/tb_execute.sv
//------------------------------------------------------------------------------
// Module      : tb_execute
// Description : Self-checking bench for the execute stage against an arithmetic model.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_execute;

    logic        clk;
    logic        reset;
    logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [18:0] RD1E, RD2E, ImmExtE, ResultW;
    logic [14:0] PCE;
    logic [4:0]  RDE;
    logic        PCSrcE;
    logic [14:0] PCTargetE;
    logic        RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [4:0]  RDM;
    logic [18:0] WriteDataM, ALUResultM;

    int checks   = 0;
    int failures = 0;

    execute dut (
        .clk        (clk),
        .reset      (reset),
        .RegWriteE  (RegWriteE),
        .MemWriteE  (MemWriteE),
        .JumpE      (JumpE),
        .BranchE    (BranchE),
        .ALUSrcE    (ALUSrcE),
        .ResultSrcE (ResultSrcE),
        .ALUControlE(ALUControlE),
        .RD1E       (RD1E),
        .RD2E       (RD2E),
        .ImmExtE    (ImmExtE),
        .PCE        (PCE),
        .RDE        (RDE),
        .ResultW    (ResultW),
        .PCSrcE     (PCSrcE),
        .PCTargetE  (PCTargetE),
        .RegWriteM  (RegWriteM),
        .MemWriteM  (MemWriteM),
        .ResultSrcM (ResultSrcM),
        .RDM        (RDM),
        .WriteDataM (WriteDataM),
        .ALUResultM (ALUResultM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam longint unsigned DMOD = 64'd524288;
    localparam longint unsigned PMOD = 64'd32768;

    // Reference ALU from plain arithmetic on wide integers
    function automatic longint unsigned refAlu(input longint unsigned a, input longint unsigned b,
                                               input int op);
        case (op)
            0: return (a + b) % DMOD;
            1: return (a + DMOD - b) % DMOD;
            2: return (a * b) % DMOD;
            3: return (b == 0) ? DMOD - 1 : a / b;
            4: return (b == 0) ? a : a % b;
            5: return a & b;
            6: return a | b;
            default: return a ^ b;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check combinational outputs now, clock once, then check the E/M register
    task automatic stepAndCheck(input string tag);
        longint unsigned b, res, tgt;
        logic            pcSrc;
        b     = ALUSrcE ? longint'(ImmExtE) : longint'(RD2E);
        res   = refAlu(longint'(RD1E), b, int'(ALUControlE));
        pcSrc = JumpE || (BranchE && res == 0);
        tgt   = (longint'(PCE) + (longint'(ImmExtE) % PMOD)) % PMOD;
        #1;
        check({tag, ".PCSrcE"}, {31'd0, PCSrcE}, {31'd0, pcSrc});
        check({tag, ".PCTargetE"}, {17'd0, PCTargetE}, tgt[31:0]);
        @(posedge clk);
        #1;
        check({tag, ".ALUResultM"}, {13'd0, ALUResultM}, res[31:0]);
        check({tag, ".WriteDataM"}, {13'd0, WriteDataM}, {13'd0, RD2E});
        check({tag, ".RDM"}, {27'd0, RDM}, {27'd0, RDE});
        check({tag, ".ctrlM"}, {28'd0, RegWriteM, MemWriteM, ResultSrcM},
              {28'd0, RegWriteE, MemWriteE, ResultSrcE});
    endtask

    task automatic setOp(input logic [18:0] a, input logic [18:0] b, input logic [18:0] imm,
                         input logic src, input logic [2:0] op);
        RD1E = a; RD2E = b; ImmExtE = imm; ALUSrcE = src; ALUControlE = op;
    endtask

    task automatic randomize_inputs();
        RegWriteE   = 1'($urandom);
        MemWriteE   = 1'($urandom);
        JumpE       = ($urandom_range(0, 7) == 0);
        BranchE     = 1'($urandom);
        ALUSrcE     = 1'($urandom);
        ResultSrcE  = 2'($urandom);
        ALUControlE = 3'($urandom);
        RD1E        = 19'($urandom);
        RD2E        = 19'($urandom);
        ImmExtE     = 19'($urandom);
        PCE         = 15'($urandom);
        RDE         = 5'($urandom);
        ResultW     = 19'($urandom);
        case ($urandom_range(0, 5))
            0: RD2E = 19'd0;
            1: ImmExtE = 19'd0;
            2: begin RD2E = RD1E; ImmExtE = RD1E; end
            3: begin RD1E = 19'($urandom_range(0, 40)); RD2E = 19'($urandom_range(0, 9)); end
            default: ;
        endcase
    endtask

    initial begin
        logic        svPcSrc;
        logic [14:0] svTgt;
        logic [18:0] svAlu;

        reset = 1'b1;
        RegWriteE = 1; MemWriteE = 1; JumpE = 0; BranchE = 0; ALUSrcE = 0;
        ResultSrcE = 2'b11; ALUControlE = 3'b000; RD1E = 19'd11; RD2E = 19'd22;
        ImmExtE = 19'd5; PCE = 15'd40; RDE = 5'd31; ResultW = 19'h1234;

        // Reset with nonzero inputs for two edges
        repeat (2) @(posedge clk);
        #1;
        check("rst.ALUResultM", {13'd0, ALUResultM}, 32'd0);
        check("rst.WriteDataM", {13'd0, WriteDataM}, 32'd0);
        check("rst.RDM", {27'd0, RDM}, 32'd0);
        check("rst.ctrlM", {28'd0, RegWriteM, MemWriteM, ResultSrcM}, 32'd0);
        check("rst.PCTargetE", {17'd0, PCTargetE}, 32'd45);

        reset = 1'b0;
        stepAndCheck("release");

        // DIV 20/10
        RegWriteE = 0; MemWriteE = 0; ResultSrcE = 2'b00; RDE = 5'd1;
        setOp(19'd20, 19'd10, 19'd0, 1'b0, 3'b011); PCE = 15'd1;
        stepAndCheck("div");
        check("div.const", {13'd0, ALUResultM}, 32'd2);

        // Immediate ADD
        setOp(19'd5, 19'd100, 19'd7, 1'b1, 3'b000); RDE = 5'd3; RegWriteE = 1;
        stepAndCheck("addi");
        check("addi.const", {13'd0, ALUResultM}, 32'd12);

        // Branch taken / not taken, negative offset
        RegWriteE = 0; BranchE = 1; PCE = 15'd100;
        setOp(19'd9, 19'd9, 19'h7FFFC, 1'b0, 3'b001);
        #1;
        check("beq.PCSrcE.const", {31'd0, PCSrcE}, 32'd1);
        check("beq.PCTargetE.const", {17'd0, PCTargetE}, 32'd96);
        stepAndCheck("beq");
        RD2E = 19'd8;
        #1;
        check("bne.PCSrcE.const", {31'd0, PCSrcE}, 32'd0);
        stepAndCheck("bne");

        // Jump with target wrap
        BranchE = 0; JumpE = 1; PCE = 15'h7FFF;
        setOp(19'd3, 19'd4, 19'd2, 1'b0, 3'b000);
        #1;
        check("jmp.PCSrcE.const", {31'd0, PCSrcE}, 32'd1);
        check("jmp.PCTargetE.const", {17'd0, PCTargetE}, 32'd1);
        stepAndCheck("jmp");
        JumpE = 0;

        // ALU corner cases
        setOp(19'd77, 19'd0, 19'd0, 1'b0, 3'b011);
        stepAndCheck("div0");
        check("div0.const", {13'd0, ALUResultM}, 32'h7FFFF);
        setOp(19'd20, 19'd0, 19'd0, 1'b0, 3'b100);
        stepAndCheck("mod0");
        check("mod0.const", {13'd0, ALUResultM}, 32'd20);
        setOp(19'd0, 19'd1, 19'd0, 1'b0, 3'b001);
        stepAndCheck("sub");
        check("sub.const", {13'd0, ALUResultM}, 32'h7FFFF);

        // ResultW must not influence anything
        BranchE = 1; setOp(19'd6, 19'd6, 19'd9, 1'b0, 3'b111);
        #1;
        svPcSrc = PCSrcE; svTgt = PCTargetE;
        ResultW = ~ResultW;
        #1;
        check("resW.PCSrcE", {31'd0, PCSrcE}, {31'd0, svPcSrc});
        check("resW.PCTargetE", {17'd0, PCTargetE}, {17'd0, svTgt});
        stepAndCheck("resW");
        svAlu = ALUResultM;
        ResultW = 19'h5A5A5;
        @(posedge clk);
        #1;
        check("resW.ALUResultM", {13'd0, ALUResultM}, {13'd0, svAlu});

        for (int i = 0; i < 300; i++) begin
            randomize_inputs();
            stepAndCheck("rand");
        end

        // Reset asserted in the middle of activity
        randomize_inputs();
        RegWriteE = 1; RDE = 5'd9; RD2E = 19'd1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrst.M", {RegWriteM, MemWriteM, ResultSrcM, RDM, WriteDataM[18:0], 4'd0},
              32'd0);
        check("midrst.ALUResultM", {13'd0, ALUResultM}, 32'd0);
        reset = 1'b0;
        stepAndCheck("postrst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
